inference_sequencer: RTL
========================

# inference_sequencer

Controls one MNIST inference per command. After software has written all 784 pixels through the loader's AXI-lite port, the sequencer pulses the image loader's `start` and gates its pixel stream into the network. It then collects the network's class scores, takes the argmax, and reports the result, status and an interrupt. It sits between the software register block, `image_loader_module`, and the network's input and output streams.

## Interface
- `NUM_PIXELS`, 784: number of pixel beats per image.
- `NUM_CLASSES`, 10: number of score beats per result.
- `DATA_W`, 32: width of a score word, signed two's complement.
- `TIMEOUT_CYCLES`, 65535: number of consecutive no-handshake cycles that counts as a stall error.
- `s_axi_aclk`  in  1  the only clock.
- `s_axi_aresetn`  in  1  reset, asynchronous and active-low.
- `cmd_go`  in  1  one-cycle pulse meaning "image loaded, run".
- `cmd_abort`  in  1  one-cycle pulse that cancels the current run.
- `loader_start`  out  1  one-cycle pulse to `image_loader_module.start`.
- `x_tvalid`  in  1  loader output valid (monitored).
- `net_tready`  in  1  ready from the network input.
- `x_tready`  out  1  ready to the loader; equals `net_tready` while in STREAM, 0 otherwise.
- `y_tdata`  in  DATA_W  network score stream.
- `y_tvalid`  in  1  score valid.
- `y_tready`  out  1  score ready.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  sticky "result valid" flag.
- `error`  out  1  sticky flag: last run was aborted or timed out.
- `irq`  out  1  one-cycle pulse at the end of every run, whether it succeeded or failed.
- `result_class`  out  $clog2(NUM_CLASSES)  argmax index.
- `result_score`  out  DATA_W  maximum score.
- `beat_count`  out  $clog2(NUM_PIXELS+1)  pixel beats accepted so far in the current run.

## Operation
States:
- IDLE -> START on `cmd_go` with no `cmd_abort` in the same cycle.
  - On entry from IDLE: clear `done`, `error`, `beat_count`, the score index and the timeout counter.
- START: drive `loader_start`=1 for exactly one cycle, then go to STREAM.
- STREAM:
  - A pixel beat counts when `x_tvalid & x_tready`; each beat increments `beat_count`.
  - The beat that brings the count to NUM_PIXELS moves the FSM to COLLECT.
- COLLECT:
  - `y_tready`=1.
  - Each `y_tvalid` beat is compared with the running maximum, signed; the first beat loads the maximum unconditionally.
  - A strictly greater score replaces the maximum, so on a tie the lowest index wins.
  - The NUM_CLASSES-th beat moves the FSM to FINISH.
- FINISH (1 cycle): register `result_class` and `result_score`, set `done`, pulse `irq`, go to IDLE.
- Timeout:
  - In STREAM and COLLECT, the counter increments on every cycle without a handshake and clears on each handshake.
  - When it reaches TIMEOUT_CYCLES: go to IDLE, set `error`, pulse `irq`, leave `done`=0.
- `cmd_abort` in any state other than IDLE: go to IDLE on the next edge, set `error`, pulse `irq`.
- `cmd_abort` in IDLE has no effect.

Boundary rules:
- `cmd_go` while `busy` is ignored.
- Abort beats a final pixel or score handshake in the same cycle, and also beats a timeout.
- `y_tvalid` outside COLLECT is not accepted (`y_tready`=0).
- Reset mid-run: outputs return to reset values immediately; the loader is not re-pulsed.

## Timing
- Reset values:
  - State IDLE.
  - `loader_start`, `busy`, `done`, `error`, `irq`, `y_tready` are all 0.
  - `result_class`, `result_score`, `beat_count` are all 0.
  - `x_tready` is 0.
- `cmd_go` sampled at edge N: state is START after N, and `loader_start` is high during cycle N+1.
- STREAM is entered after edge N+1.
- `x_tready` is combinational: `net_tready & (state==STREAM)`. No added latency; no bubbles under continuous valid/ready.
- The final score beat at edge M gives FINISH during cycle M+1.
  - `done`, `result_*` and `irq` are visible during cycle M+2, one cycle after FINISH.
  - `irq` lasts one cycle.
- Minimum run length: 1 + NUM_PIXELS + NUM_CLASSES + 2 cycles.
- All registered outputs change only on the `s_axi_aclk` rising edge.

## Structure
- Shared package `mnist_pkg` holds:
  - the state enum (IDLE, START, STREAM, COLLECT, FINISH);
  - NUM_PIXELS, NUM_CLASSES, DATA_W;
  - the index-width constants.
- Sub-module `argmax_unit` holds the running max/index registers with `clear` and `sample` inputs and the signed compare. The FSM, counters and timeout stay in the top module.

## Test plan
- Normal run:
  - Stimulus: `cmd_go`; 784 beats with `net_tready`=1; scores {3,-5,9,2,9,0,1,-1,4,7}.
  - Required: `result_class`=2, `result_score`=9, `done`=1, `error`=0, one `irq`; `loader_start` exactly once, one cycle after go.
- Backpressure:
  - Stimulus: `net_tready` toggling randomly and `y_tvalid` gaps shorter than the timeout.
  - Required: `beat_count` reaches 784 exactly; same result as the normal run; `x_tready`=0 in all other states.
- All-negative scores:
  - Stimulus: scores {-8,-2,-3,-2,-9,-10,-7,-4,-6,-5}.
  - Required: `result_class`=1, `result_score`=-2 (signed compare, tie to lowest index).
- Abort:
  - Stimulus: `cmd_abort` at beat 400.
  - Required: IDLE next cycle, `error`=1, `done`=0, one `irq`, `x_tready`=0. A following `cmd_go` clears `error` and runs correctly.
- Timeout and ignored go:
  - Stimulus: stop `x_tvalid` after beat 10, with TIMEOUT_CYCLES=100 in the bench; separately, issue `cmd_go` during STREAM.
  - Required: `error` and `irq` after exactly 100 idle cycles. The extra go produces no second `loader_start`.
- Reset mid-COLLECT:
  - Stimulus: drop `s_axi_aresetn` asynchronously.
  - Required: all outputs go to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/mnist_pkg.sv
// Shared constants and types for the MNIST inference sequencer.
// State encoding and index widths used by the top and its sub-units.
package mnist_pkg;

  localparam int NUM_PIXELS  = 784;
  localparam int NUM_CLASSES = 10;
  localparam int DATA_W      = 32;

  localparam int PIX_W = $clog2(NUM_PIXELS + 1);
  localparam int IDX_W = $clog2(NUM_CLASSES);

  typedef enum logic [2:0] {
    IDLE,
    START,
    STREAM,
    COLLECT,
    FINISH
  } state_t;

endpackage

// File: rtl/inference_sequencer_if.sv
// Command, stream and status bundle of the inference sequencer.
// The sequencer takes the slave side; software/loader/network the master.
interface inference_sequencer_if;
  import mnist_pkg::*;

  logic              cmd_go;
  logic              cmd_abort;
  logic              loader_start;
  logic              x_tvalid;
  logic              net_tready;
  logic              x_tready;
  logic [DATA_W-1:0] y_tdata;
  logic              y_tvalid;
  logic              y_tready;
  logic              busy;
  logic              done;
  logic              error;
  logic              irq;
  logic [IDX_W-1:0]  result_class;
  logic [DATA_W-1:0] result_score;
  logic [PIX_W-1:0]  beat_count;

  modport master (
    output cmd_go, cmd_abort, x_tvalid,
    output net_tready, y_tdata, y_tvalid,
    input  loader_start, x_tready, y_tready,
    input  busy, done, error, irq,
    input  result_class, result_score, beat_count
  );

  modport slave (
    input  cmd_go, cmd_abort, x_tvalid,
    input  net_tready, y_tdata, y_tvalid,
    output loader_start, x_tready, y_tready,
    output busy, done, error, irq,
    output result_class, result_score, beat_count
  );

endinterface

// File: rtl/argmax_unit.sv
// Running signed maximum over the class score stream.
// Ties keep the earlier (lower) index.
module argmax_unit
  import mnist_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              sample,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] score,
  output logic [IDX_W-1:0]  max_idx,
  output logic [DATA_W-1:0] max_score
);

  logic have;
  logic take;

  assign take = sample &
    (~have | ($signed(score) > $signed(max_score)));

  // first sample loads, later ones replace only when strictly greater
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      have      <= 1'b0;
      max_idx   <= '0;
      max_score <= '0;
    end else if (clear) begin
      have <= 1'b0;
    end else if (take) begin
      have      <= 1'b1;
      max_idx   <= idx;
      max_score <= score;
    end
  end

endmodule

// File: rtl/inference_sequencer.sv
// Sequences one MNIST inference: loader start, pixel gating,
// score collection, argmax result, status flags and interrupt.
module inference_sequencer
  import mnist_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input logic                  s_axi_aclk,
  input logic                  s_axi_aresetn,
  inference_sequencer_if.slave bus
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t            state;
  state_t            state_n;
  logic [PIX_W-1:0]  beats;
  logic [IDX_W-1:0]  y_idx;
  logic [TO_W-1:0]   to_cnt;
  logic              done;
  logic              error;
  logic              irq;
  logic [IDX_W-1:0]  res_cls;
  logic [DATA_W-1:0] res_score;
  logic [IDX_W-1:0]  max_idx;
  logic [DATA_W-1:0] max_score;

  logic busy;
  logic px_hs;
  logic y_hs;
  logic waiting;
  logic to_hit;
  logic last_px;
  logic last_y;
  logic go_evt;
  logic fail_evt;
  logic ok_evt;

  assign busy    = (state != IDLE);
  assign waiting = (state == STREAM) | (state == COLLECT);

  assign bus.x_tready     = bus.net_tready & (state == STREAM);
  assign bus.y_tready     = (state == COLLECT);
  assign bus.loader_start = (state == START);
  assign bus.busy         = busy;
  assign bus.done         = done;
  assign bus.error        = error;
  assign bus.irq          = irq;
  assign bus.result_class = res_cls;
  assign bus.result_score = res_score;
  assign bus.beat_count   = beats;

  assign px_hs = bus.x_tvalid & bus.x_tready;
  assign y_hs  = bus.y_tvalid & bus.y_tready;

  assign to_hit = waiting & ~(px_hs | y_hs) &
    (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  assign last_px = px_hs &
    (beats == PIX_W'(NUM_PIXELS - 1));
  assign last_y = y_hs &
    (y_idx == IDX_W'(NUM_CLASSES - 1));

  assign go_evt   = (state == IDLE) & bus.cmd_go & ~bus.cmd_abort;
  assign fail_evt = busy & (bus.cmd_abort | to_hit);
  assign ok_evt   = (state == FINISH) & ~bus.cmd_abort;

  // state register
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) state <= IDLE;
    else                state <= state_n;
  end

  // next state; abort overrides every other transition
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (go_evt) state_n = START;
      START:   state_n = STREAM;
      STREAM:  if (last_px)     state_n = COLLECT;
               else if (to_hit) state_n = IDLE;
      COLLECT: if (last_y)      state_n = FINISH;
               else if (to_hit) state_n = IDLE;
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (busy & bus.cmd_abort) state_n = IDLE;
  end

  // counters, timeout, sticky flags, result and irq
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      beats     <= '0;
      y_idx     <= '0;
      to_cnt    <= '0;
      done      <= 1'b0;
      error     <= 1'b0;
      irq       <= 1'b0;
      res_cls   <= '0;
      res_score <= '0;
    end else begin
      irq <= ok_evt | fail_evt;
      if (go_evt) begin
        beats  <= '0;
        y_idx  <= '0;
        to_cnt <= '0;
        done   <= 1'b0;
        error  <= 1'b0;
      end else begin
        if (px_hs) beats <= beats + PIX_W'(1);
        if (y_hs)  y_idx <= y_idx + IDX_W'(1);
        if (!waiting || px_hs || y_hs) to_cnt <= '0;
        else                           to_cnt <= to_cnt + TO_W'(1);
        if (fail_evt) error <= 1'b1;
        if (ok_evt) begin
          done      <= 1'b1;
          res_cls   <= max_idx;
          res_score <= max_score;
        end
      end
    end
  end

  argmax_unit u_argmax (
    .clk       (s_axi_aclk),
    .rst_n     (s_axi_aresetn),
    .clear     (go_evt),
    .sample    (y_hs),
    .idx       (y_idx),
    .score     (bus.y_tdata),
    .max_idx   (max_idx),
    .max_score (max_score)
  );

endmodule
